// File: rtl/bp_be_stride_prefetch_issuer_pkg.sv
// ---------------------------------------------------------------------------
// bp_be_pkg
//   Shared BE-checker definitions used by the stride prefetch issuer:
//   processor config selector, job record and issuer FSM state encoding.
//   No ports (package).
// ---------------------------------------------------------------------------
package bp_be_pkg;

    // Processor configuration selector; only the default core exists here.
    typedef enum int {
        e_bp_default_cfg = 0
    } bp_params_e;

    // Virtual address width supplied by a processor configuration.
    function automatic int bp_vaddr_width(input bp_params_e cfg);
        int w;
        case (cfg)
            e_bp_default_cfg: w = 39;
            default:          w = 39;
        endcase
        return w;
    endfunction

    localparam int pf_vaddr_width_gp     = 39;
    localparam int pf_stride_width_gp    = 8;
    localparam int pf_output_range_gp    = 8;

    // One confirmed striding-load job as handed over by loop inference.
    typedef struct packed {
        logic [pf_vaddr_width_gp-1:0]  pc;
        logic [pf_vaddr_width_gp-1:0]  eff_addr;
        logic [pf_stride_width_gp-1:0] stride;
        logic [pf_output_range_gp-1:0] remaining;
    } bp_be_pf_job_s;

    typedef enum logic {
        e_pf_idle  = 1'b0,
        e_pf_issue = 1'b1
    } bp_be_pf_state_e;

endpackage

// File: rtl/bp_be_stride_prefetch_issuer_if.sv
// ---------------------------------------------------------------------------
// bp_be_stride_prefetch_issuer_if
//   Bundles the job handshake from loop inference, the D$ prefetch request
//   port, the pipeline flush and the busy indication.
//   master : drives job fields, pf_ready_and_i, flush_i (producer / D$ side)
//   slave  : the issuer; drives yumi_o, pf_v_o, pf_addr_o, pf_pc_o, busy_o
// ---------------------------------------------------------------------------
interface bp_be_stride_prefetch_issuer_if
    #(parameter int vaddr_width_p          = 39
    , parameter int effective_addr_width_p = 39
    , parameter int stride_width_p         = 8
    , parameter int output_range_p         = 8
    );

    logic                              v_i;
    logic [vaddr_width_p-1:0]          pc_i;
    logic [effective_addr_width_p-1:0] eff_addr_i;
    logic [stride_width_p-1:0]         stride_i;
    logic [output_range_p-1:0]         remaining_iterations_i;
    logic                              yumi_o;

    logic                              pf_v_o;
    logic [effective_addr_width_p-1:0] pf_addr_o;
    logic [vaddr_width_p-1:0]          pf_pc_o;
    logic                              pf_ready_and_i;

    logic                              flush_i;
    logic                              busy_o;

    modport master (
        output v_i, pc_i, eff_addr_i, stride_i, remaining_iterations_i,
               pf_ready_and_i, flush_i,
        input  yumi_o, pf_v_o, pf_addr_o, pf_pc_o, busy_o
    );

    modport slave (
        input  v_i, pc_i, eff_addr_i, stride_i, remaining_iterations_i,
               pf_ready_and_i, flush_i,
        output yumi_o, pf_v_o, pf_addr_o, pf_pc_o, busy_o
    );

endinterface

// File: rtl/bp_be_stride_prefetch_issuer_pf_addr_gen.sv
// ---------------------------------------------------------------------------
// bp_be_pf_addr_gen
//   Address walker for the prefetch issuer. Holds the current address and the
//   sign-extended stride, produces the block-aligned address, and remembers
//   the last issued block so repeat requests to the same block are flagged.
//   Ports:
//     clk_i, reset_i : clock, asynchronous active-low reset
//     load_i         : start a new job (cur = eff_addr + stride, forget block)
//     eff_addr_i     : last observed effective address of the job
//     stride_i       : signed byte stride
//     advance_i      : step cur_addr by the stride
//     commit_i       : record the current block as the last issued one
//     blk_o          : current address with block-offset bits cleared
//     dup_o          : current block equals the last issued block
// ---------------------------------------------------------------------------
module bp_be_pf_addr_gen
    #(parameter int addr_width_p     = 39
    , parameter int stride_width_p   = 8
    , parameter int lg_block_bytes_p = 6
    )
    (input  logic                      clk_i
    , input  logic                     reset_i
    , input  logic                     load_i
    , input  logic [addr_width_p-1:0]  eff_addr_i
    , input  logic [stride_width_p-1:0] stride_i
    , input  logic                     advance_i
    , input  logic                     commit_i
    , output logic [addr_width_p-1:0]  blk_o
    , output logic                     dup_o
    );

    logic [addr_width_p-1:0] stride_sext;
    logic [addr_width_p-1:0] cur_addr_r;
    logic [addr_width_p-1:0] stride_r;
    logic [addr_width_p-1:0] last_blk_r;
    logic                    last_blk_v_r;

    assign stride_sext = {{(addr_width_p-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};

    // Address sums wrap modulo 2^addr_width_p; prefetch hints may wrap freely.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cur_addr_r   <= '0;
            stride_r     <= '0;
            last_blk_r   <= '0;
            last_blk_v_r <= 1'b0;
        end else if (load_i) begin
            cur_addr_r   <= eff_addr_i + stride_sext;
            stride_r     <= stride_sext;
            last_blk_v_r <= 1'b0;
        end else begin
            if (advance_i) begin
                cur_addr_r <= cur_addr_r + stride_r;
            end
            if (commit_i) begin
                last_blk_r   <= blk_o;
                last_blk_v_r <= 1'b1;
            end
        end
    end

    assign blk_o = {cur_addr_r[addr_width_p-1:lg_block_bytes_p], {lg_block_bytes_p{1'b0}}};
    assign dup_o = last_blk_v_r & (blk_o == last_blk_r);

endmodule

// File: rtl/bp_be_stride_prefetch_issuer.sv
// ---------------------------------------------------------------------------
// bp_be_stride_prefetch_issuer
//   Accepts one confirmed striding-load job at a time and expands it into at
//   most max_depth_p block-aligned prefetch requests toward the D$ prefetch
//   port, skipping requests that land in the block just issued.
//   Ports:
//     clk_i   : clock
//     reset_i : asynchronous reset, active low
//     io      : job handshake (v_i/yumi_o + job fields), prefetch request
//               (pf_v_o/pf_ready_and_i, pf_addr_o, pf_pc_o), flush_i, busy_o
// ---------------------------------------------------------------------------
module bp_be_stride_prefetch_issuer
    import bp_be_pkg::*;
    #(parameter bp_params_e bp_params_p = e_bp_default_cfg
    , localparam int vaddr_width_p      = bp_vaddr_width(bp_params_p)
    , parameter int output_range_p      = 8
    , parameter int effective_addr_width_p = vaddr_width_p
    , parameter int stride_width_p      = 8
    , parameter int max_depth_p         = 16
    , parameter int lg_block_bytes_p    = 6
    )
    (input  logic clk_i
    , input  logic reset_i
    , bp_be_stride_prefetch_issuer_if.slave io
    );

    localparam int cnt_width_lp = $clog2(max_depth_p + 1);

    bp_be_pf_state_e                   state_r;
    logic [cnt_width_lp-1:0]           cnt_r;
    logic [cnt_width_lp-1:0]           cnt_init;
    logic [vaddr_width_p-1:0]          pc_r;
    logic                              issue;
    logic                              yumi;
    logic                              drop;
    logic                              step;
    logic                              dup;
    logic [effective_addr_width_p-1:0] blk;

    assign issue = (state_r == e_pf_issue);

    // Gated by reset so the handshake reads 0 while the block is held in reset.
    assign yumi = reset_i & ~issue & io.v_i & ~io.flush_i;

    // A step retires one candidate address: either a skipped duplicate or an
    // accepted request. A flush cycle never steps.
    assign step = issue & ~io.flush_i & (dup | io.pf_ready_and_i);

    // Clamp the iteration estimate to the prefetch depth.
    always_comb begin
        cnt_init = '0;
        if (int'(io.remaining_iterations_i) > max_depth_p) begin
            cnt_init = cnt_width_lp'(max_depth_p);
        end else begin
            cnt_init = cnt_width_lp'(io.remaining_iterations_i);
        end
    end

    // Jobs that would produce nothing are consumed but never enter ISSUE.
    assign drop = (cnt_init == '0) | (io.stride_i == '0);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r <= e_pf_idle;
            cnt_r   <= '0;
            pc_r    <= '0;
        end else begin
            case (state_r)
                e_pf_idle: begin
                    if (yumi) begin
                        pc_r  <= io.pc_i;
                        cnt_r <= cnt_init;
                        if (!drop) begin
                            state_r <= e_pf_issue;
                        end
                    end
                end
                e_pf_issue: begin
                    if (io.flush_i) begin
                        state_r <= e_pf_idle;
                    end else if (step) begin
                        cnt_r <= cnt_r - cnt_width_lp'(1);
                        if (cnt_r == cnt_width_lp'(1)) begin
                            state_r <= e_pf_idle;
                        end
                    end
                end
                default: state_r <= e_pf_idle;
            endcase
        end
    end

    bp_be_pf_addr_gen
        #(.addr_width_p     (effective_addr_width_p)
        , .stride_width_p   (stride_width_p)
        , .lg_block_bytes_p (lg_block_bytes_p)
        )
        addr_gen
        (.clk_i      (clk_i)
        , .reset_i   (reset_i)
        , .load_i    (yumi)
        , .eff_addr_i(io.eff_addr_i)
        , .stride_i  (io.stride_i)
        , .advance_i (step)
        , .commit_i  (step & ~dup)
        , .blk_o     (blk)
        , .dup_o     (dup)
        );

    // Address and PC come straight from registers, so they cannot move while
    // a request waits for ready.
    assign io.yumi_o    = yumi;
    assign io.pf_v_o    = issue & ~dup & ~io.flush_i;
    assign io.pf_addr_o = blk;
    assign io.pf_pc_o   = pc_r;
    assign io.busy_o    = issue;

endmodule

// File: tb/tb_bp_be_stride_prefetch_issuer.sv
// ---------------------------------------------------------------------------
// tb_bp_be_stride_prefetch_issuer
//   Self-checking bench for the stride prefetch issuer. Directed jobs from the
//   test plan plus randomized jobs, compared to a list-of-addresses model.
// ---------------------------------------------------------------------------
module tb_bp_be_stride_prefetch_issuer;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;

    int checkCount = 0;
    int errorCount = 0;

    logic [38:0] expQ[$];

    always #5 clk_i = ~clk_i;

    bp_be_stride_prefetch_issuer_if pfIf ();

    bp_be_stride_prefetch_issuer dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .io      (pfIf.slave)
    );

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: walk the job with plain arithmetic and list the block
    // addresses that should be requested, dropping immediate repeats.
    function automatic int buildExpected(input logic [38:0] eff, input logic [7:0] stride, input logic [7:0] rem);
        int          n;
        logic [38:0] addr;
        logic [38:0] blkAddr;
        logic [38:0] lastBlk;
        bit          haveLast;
        expQ.delete();
        n = (rem > 8'd16) ? 16 : int'(rem);
        if (stride == 8'd0) n = 0;
        addr = eff;
        haveLast = 1'b0;
        lastBlk = '0;
        for (int i = 0; i < n; i++) begin
            addr = addr + {{31{stride[7]}}, stride};
            blkAddr = addr & ~39'h3F;
            if (!haveLast || blkAddr != lastBlk) expQ.push_back(blkAddr);
            lastBlk = blkAddr;
            haveLast = 1'b1;
        end
        return n;
    endfunction

    // Runs one job. Entered and left at posedge+1.
    // mode 0: ready always high, 1: random ready, 2: 5 stall cycles on 2nd request.
    // flushAt >= 0 flushes the job while that many requests have been accepted.
    task automatic applyStimulus(input logic [38:0] eff, input logic [7:0] stride, input logic [7:0] rem,
                                 input int mode, input int flushAt);
        int          steps;
        int          got;
        int          stalls;
        int          cycles;
        bit          stalled;
        bit          flushed;
        bit          done;
        bit          flushNow;
        logic [38:0] heldAddr;
        logic [38:0] pc;
        steps = buildExpected(eff, stride, rem);
        pc = 39'({$urandom(), $urandom()});
        pfIf.v_i = 1'b1;
        pfIf.pc_i = pc;
        pfIf.eff_addr_i = eff;
        pfIf.stride_i = stride;
        pfIf.remaining_iterations_i = rem;
        pfIf.pf_ready_and_i = 1'b0;
        pfIf.flush_i = 1'b0;
        #4;
        checkOutput("yumi_accept", 64'(pfIf.yumi_o), 64'd1);
        checkOutput("busy_before", 64'(pfIf.busy_o), 64'd0);
        checkOutput("pf_v_before", 64'(pfIf.pf_v_o), 64'd0);
        @(posedge clk_i);
        #1;
        got = 0;
        stalls = 0;
        cycles = 0;
        stalled = 1'b0;
        flushed = 1'b0;
        done = 1'b0;
        heldAddr = '0;
        while (!done && cycles < 200) begin
            case (mode)
                0:       pfIf.pf_ready_and_i = 1'b1;
                1:       pfIf.pf_ready_and_i = ($urandom_range(0, 3) != 0);
                default: pfIf.pf_ready_and_i = !(got == 1 && stalls < 5);
            endcase
            flushNow = (flushAt == got);
            pfIf.flush_i = flushNow;
            pfIf.v_i = 1'b1;
            #4;
            if (!pfIf.busy_o) begin
                pfIf.v_i = 1'b0;
                checkOutput("idle_pf_v", 64'(pfIf.pf_v_o), 64'd0);
                done = 1'b1;
            end else begin
                cycles++;
                checkOutput("yumi_busy", 64'(pfIf.yumi_o), 64'd0);
                if (flushNow) begin
                    checkOutput("flush_pf_v", 64'(pfIf.pf_v_o), 64'd0);
                    flushed = 1'b1;
                    done = 1'b1;
                end else if (pfIf.pf_v_o) begin
                    checkOutput("pf_pc", 64'(pfIf.pf_pc_o), 64'(pc));
                    if (stalled) checkOutput("held_addr", 64'(pfIf.pf_addr_o), 64'(heldAddr));
                    if (got < expQ.size()) begin
                        checkOutput($sformatf("req%0d_addr", got), 64'(pfIf.pf_addr_o), 64'(expQ[got]));
                    end else begin
                        checkOutput("extra_req", 64'(pfIf.pf_v_o), 64'd0);
                    end
                    if (pfIf.pf_ready_and_i) begin
                        got++;
                        stalled = 1'b0;
                    end else begin
                        stalls++;
                        stalled = 1'b1;
                        heldAddr = pfIf.pf_addr_o;
                    end
                end
            end
            @(posedge clk_i);
            #1;
            pfIf.flush_i = 1'b0;
            pfIf.v_i = 1'b0;
        end
        checkOutput("job_done", 64'(done), 64'd1);
        if (flushed) begin
            checkOutput("flush_count", 64'(got), 64'(flushAt));
        end else begin
            checkOutput("req_count", 64'(got), 64'(expQ.size()));
            checkOutput("busy_cycles", 64'(cycles), 64'(steps + stalls));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pf_v"},    64'(pfIf.pf_v_o),    64'd0);
        checkOutput({tag, "_yumi"},    64'(pfIf.yumi_o),    64'd0);
        checkOutput({tag, "_busy"},    64'(pfIf.busy_o),    64'd0);
        checkOutput({tag, "_pf_addr"}, 64'(pfIf.pf_addr_o), 64'd0);
        checkOutput({tag, "_pf_pc"},   64'(pfIf.pf_pc_o),   64'd0);
    endtask

    initial begin
        pfIf.v_i = 1'b1;
        pfIf.pc_i = 39'h123;
        pfIf.eff_addr_i = 39'h1000;
        pfIf.stride_i = 8'd64;
        pfIf.remaining_iterations_i = 8'd3;
        pfIf.pf_ready_and_i = 1'b1;
        pfIf.flush_i = 1'b0;
        #12;
        checkAllZero("reset");
        pfIf.v_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;

        $display("[TB] basic job");
        applyStimulus(39'h1000, 8'd64, 8'd3, 0, -1);
        $display("[TB] clamp to depth");
        applyStimulus(39'h4000, 8'd64, 8'd200, 0, -1);
        checkOutput("clamp_model_len", 64'(expQ.size()), 64'd16);
        $display("[TB] zero remaining / zero stride");
        applyStimulus(39'h1000, 8'd64, 8'd0, 0, -1);
        applyStimulus(39'h1000, 8'd0, 8'd5, 0, -1);
        $display("[TB] negative stride with dedupe");
        applyStimulus(39'h1040, 8'hF8, 8'd10, 0, -1);
        $display("[TB] backpressure on second request");
        applyStimulus(39'h1000, 8'd64, 8'd3, 2, -1);
        $display("[TB] flush on second request then back-to-back job");
        applyStimulus(39'h1000, 8'd64, 8'd3, 0, 1);
        applyStimulus(39'h3000, 8'd64, 8'd2, 0, -1);
        $display("[TB] address wrap");
        applyStimulus(39'h7F_FFFF_FFC0, 8'd64, 8'd3, 0, -1);

        $display("[TB] random jobs");
        for (int j = 0; j < 24; j++) begin
            applyStimulus(39'({$urandom(), $urandom()}), 8'($urandom()), 8'($urandom_range(0, 40)), 1, -1);
        end

        $display("[TB] reset mid-job");
        pfIf.v_i = 1'b1;
        pfIf.pc_i = 39'h555;
        pfIf.eff_addr_i = 39'h2000;
        pfIf.stride_i = 8'd64;
        pfIf.remaining_iterations_i = 8'd8;
        pfIf.pf_ready_and_i = 1'b1;
        @(posedge clk_i);
        #1;
        pfIf.v_i = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("midjob_busy", 64'(pfIf.busy_o), 64'd1);
        reset_i = 1'b0;
        #1;
        checkAllZero("midjob_reset");
        @(negedge clk_i);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        applyStimulus(39'h8000, 8'd32, 8'd4, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
